multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main sequencing FSM of the multicycle 16-bit RISC core. Takes the opcode held in the instruction register and steps each instruction through fetch, decode, execute, memory and write-back cycles. It drives the datapath mux selects, write enables and the memory request handshake. It also drives the 4-bit opcode input of the downstream ALU control decoder, forcing an add or subtract opcode during PC increment, address calculation and branch compare.

## Interface
- RETIRE_W, 16, width of the retired-instruction counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  4  IR[15:12]
- mem_ready  in  1  memory has completed the current request this cycle
- mem_req  out  1  memory access request; held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 reg B, 01 constant 1, 10 sign-extended imm
- alu_opcode  out  4  opcode presented to ALU control
- reg_write, reg_dst, mem_to_reg  out  1 each  register file controls
- halted  out  1  high in HALT state
- illegal  out  1  one-cycle pulse on undefined opcode
- retired  out  RETIRE_W  count of completed instructions

## Operation
- Opcodes: 0000 R-type, 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 0101 JMP, 1111 HALT. All others are illegal.
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT.
- Outputs are Moore-decoded from state, except that pc_write and ir_write in FETCH are gated by mem_ready. Every output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_opcode=0001 (add), pc_src=00.
  - On mem_ready: ir_write=1, pc_write=1, next state DECODE.
  - Otherwise: stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=10, alu_opcode=0001 (branch target into ALUOut). Next state by opcode:
  - 0000 → EXEC_R; 0001 → EXEC_I; 0010/0011 → MEM_ADDR; 0100 → BRANCH; 0101 → JUMP; 1111 → HALT.
  - Illegal: illegal=1 for this one cycle, next state FETCH, instruction not retired.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_opcode=opcode. Next state ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_opcode=opcode. Next state ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. reg_dst=1 for R-type, 0 for ADDI. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_opcode=0001. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_req=1, i_or_d=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEM_WR: mem_req=1, mem_we=1, i_or_d=1. Wait for mem_ready, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_opcode=0100 (subtract), pc_write_cond=1, pc_src=01. Next state FETCH.
- JUMP: pc_write=1, pc_src=10. Next state FETCH.
- HALT: halted=1. Stays in HALT until reset; all other inputs are ignored.
- retired increments by 1 on each exit from ALU_WB, MEM_WB, MEM_WR, BRANCH or JUMP, and on entry to HALT. It wraps from all-ones to 0.

## Timing
- Reset (asynchronous): state=IDLE, retired=0, and every output is 0 from assertion until the first clock edge after deassertion.
- Reset during a pending mem_req drops the request immediately. A mem_ready arriving during reset is ignored.
- State and retired update on the rising edge of clk.
- Minimum cycle counts, from FETCH entry to the next FETCH entry, with mem_ready=1 on every request cycle:
  - R-type and ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ and JMP: 3.
- Each wait cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly 1 cycle.
- mem_req remains high and i_or_d and mem_we remain stable throughout a wait.
- mem_ready sampled outside FETCH, MEM_RD and MEM_WR has no effect.
- The first FETCH begins 1 cycle after reset release (IDLE lasts 1 cycle).

## Test plan
- Reset release, opcode=0000, mem_ready tied 1:
  - State sequence IDLE, FETCH, DECODE, EXEC_R, ALU_WB, FETCH.
  - alu_opcode sequence 0001, 0001, 0000 in FETCH, DECODE, EXEC_R.
  - reg_write=1 with reg_dst=1 in ALU_WB; retired=1 after ALU_WB.
- LW (opcode=0010) with mem_ready low for 3 cycles in MEM_RD:
  - mem_req held high with i_or_d=1 for 4 cycles.
  - MEM_WB shows reg_write=1 and mem_to_reg=1; total 8 cycles FETCH to FETCH.
- Opcode=0111: illegal pulses for exactly 1 cycle in DECODE, FETCH follows, and retired is unchanged.
- BEQ (0100): BRANCH state shows alu_opcode=0100, pc_write_cond=1 and pc_src=01; 3 cycles total.
- Opcode=1111: halted=1 and stays high for 20 cycles despite opcode changes and mem_ready toggling; retired increments once.
- Reset asserted mid-MEM_WR with mem_req high: mem_req falls with no clock edge, and the FSM restarts at IDLE with retired=0. Separately, preload retired to all-ones and run one JMP: retired wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
// Main sequencing FSM of the multicycle 16-bit core. It walks each instruction
// through fetch, decode, execute, memory and write-back. It also drives the
// datapath selects and enables, the memory request handshake and the opcode
// presented to the ALU control decoder.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | one cycle after reset release, all outputs low
// FETCH     | read instruction at PC, PC+1 into PC when memory is ready
// DECODE    | branch target into ALUOut, dispatch on opcode
// EXEC_R    | reg A op reg B
// EXEC_I    | reg A op sign-extended immediate
// ALU_WB    | ALUOut into register file (rd for R-type, rt for ADDI)
// MEM_ADDR  | effective address = reg A + imm
// MEM_RD    | data read at ALUOut, held until memory is ready
// MEM_WB    | memory data into register file
// MEM_WR    | data write at ALUOut, held until memory is ready
// BRANCH    | A - B compare, conditional PC load from ALUOut
// JUMP      | PC load from jump target
// HALT      | parked until reset

module multicycle_control #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [3:0]          alu_opcode,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_LW   = 4'b0010;
    localparam logic [3:0] OP_SW   = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_JMP  = 4'b0101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0100;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    state_t state;
    state_t state_n;
    logic   retire_now;

    // State register; reset parks the FSM in IDLE so every output drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state selection from current state, opcode and memory handshake.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     state_n = S_FETCH;
            S_FETCH:    if (mem_ready) state_n = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:         state_n = S_EXEC_R;
                    OP_ADDI:      state_n = S_EXEC_I;
                    OP_LW, OP_SW: state_n = S_MEM_ADDR;
                    OP_BEQ:       state_n = S_BRANCH;
                    OP_JMP:       state_n = S_JUMP;
                    OP_HALT:      state_n = S_HALT;
                    default:      state_n = S_FETCH;
                endcase
            end
            S_EXEC_R:   state_n = S_ALU_WB;
            S_EXEC_I:   state_n = S_ALU_WB;
            S_ALU_WB:   state_n = S_FETCH;
            S_MEM_ADDR: state_n = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_n = S_MEM_WB;
            S_MEM_WB:   state_n = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_n = S_FETCH;
            S_BRANCH:   state_n = S_FETCH;
            S_JUMP:     state_n = S_FETCH;
            S_HALT:     state_n = S_HALT;
            default:    state_n = S_IDLE;
        endcase
    end

    // Moore output decode; only the FETCH load enables look at mem_ready.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_opcode    = 4'b0000;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        halted        = 1'b0;
        illegal       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b01;
                alu_opcode = ALU_ADD;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b10;
                alu_opcode = ALU_ADD;
                illegal    = !(opcode inside {OP_R, OP_ADDI, OP_LW, OP_SW,
                                              OP_BEQ, OP_JMP, OP_HALT});
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_opcode = opcode;
            end
            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_opcode = opcode;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (opcode == OP_R);
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_opcode = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_opcode    = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // An instruction retires on its final cycle; HALT retires as it is entered.
    always_comb begin
        retire_now = 1'b0;
        case (state)
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: retire_now = 1'b1;
            S_MEM_WR: retire_now = mem_ready;
            S_DECODE: retire_now = (opcode == OP_HALT);
            default:  retire_now = 1'b0;
        endcase
    end

    // Retired-instruction counter, wraps naturally at full scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (retire_now) begin
            retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Each instruction is expanded into the list of
// cycles it must occupy, given its opcode and the number of memory wait cycles,
// and every cycle's outputs and the retired count are compared.
`timescale 1ns/1ps

module tb_multicycle_control;

    localparam int RW = 6;

    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC_R = 3,
                   PH_EXEC_I = 4, PH_ALU_WB = 5, PH_MEM_ADDR = 6, PH_MEM_RD = 7,
                   PH_MEM_WB = 8, PH_MEM_WR = 9, PH_BRANCH = 10, PH_JUMP = 11,
                   PH_HALT = 12;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_opcode;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       halted;
        logic       illegal;
    } outs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    opcode = 4'h0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0]    pc_src;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [3:0]    alu_opcode;
    logic          reg_write, reg_dst, mem_to_reg, halted, illegal;
    logic [RW-1:0] retired;
    outs_t         obs;

    logic [RW-1:0] rmodel = '0;
    int            checks = 0;
    int            failures = 0;

    multicycle_control #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_opcode(alu_opcode), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .halted(halted), .illegal(illegal),
        .retired(retired)
    );

    assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
                  pc_src, alu_src_a, alu_src_b, alu_opcode, reg_write, reg_dst,
                  mem_to_reg, halted, illegal};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] op);
        return (op <= 4'h5) || (op == 4'hF);
    endfunction

    // What each cycle of an instruction must drive.
    function automatic outs_t expect_out(input int ph, input logic [3:0] op, input logic rdy);
        outs_t o;
        o = '0;
        case (ph)
            PH_FETCH: begin
                o.mem_req = 1'b1; o.alu_src_b = 2'b01; o.alu_opcode = 4'b0001;
                o.ir_write = rdy; o.pc_write = rdy;
            end
            PH_DECODE: begin
                o.alu_src_b = 2'b10; o.alu_opcode = 4'b0001; o.illegal = !is_legal(op);
            end
            PH_EXEC_R:   begin o.alu_src_a = 1'b1; o.alu_opcode = op; end
            PH_EXEC_I:   begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_opcode = op; end
            PH_ALU_WB:   begin o.reg_write = 1'b1; o.reg_dst = (op == 4'h0); end
            PH_MEM_ADDR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_opcode = 4'b0001; end
            PH_MEM_RD:   begin o.mem_req = 1'b1; o.i_or_d = 1'b1; end
            PH_MEM_WB:   begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
            PH_MEM_WR:   begin o.mem_req = 1'b1; o.mem_we = 1'b1; o.i_or_d = 1'b1; end
            PH_BRANCH: begin
                o.alu_src_a = 1'b1; o.alu_opcode = 4'b0100; o.pc_write_cond = 1'b1; o.pc_src = 2'b01;
            end
            PH_JUMP:     begin o.pc_write = 1'b1; o.pc_src = 2'b10; end
            PH_HALT:     o.halted = 1'b1;
            default:     o = '0;
        endcase
        return o;
    endfunction

    task automatic do_cycle(input int ph, input logic [3:0] op, input logic rdy, input string tag);
        @(posedge clk);
        #1;
        opcode    = op;
        mem_ready = rdy;
        @(negedge clk);
        chk(tag, 32'(obs), 32'(expect_out(ph, op, rdy)));
        chk({tag, "_ret"}, 32'(retired), 32'(rmodel));
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction: fw fetch waits, mw data-memory waits.
    task automatic run_instr(input logic [3:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) do_cycle(PH_FETCH, 4'($urandom), 1'b0, "fetch_wait");
        do_cycle(PH_FETCH, 4'($urandom), 1'b1, "fetch");
        do_cycle(PH_DECODE, op, rbit(), "decode");
        case (op)
            4'h0: begin do_cycle(PH_EXEC_R, op, rbit(), "exec_r"); do_cycle(PH_ALU_WB, op, rbit(), "alu_wb"); end
            4'h1: begin do_cycle(PH_EXEC_I, op, rbit(), "exec_i"); do_cycle(PH_ALU_WB, op, rbit(), "alu_wb"); end
            4'h2: begin
                do_cycle(PH_MEM_ADDR, op, rbit(), "mem_addr");
                for (int i = 0; i < mw; i++) do_cycle(PH_MEM_RD, op, 1'b0, "mem_rd_wait");
                do_cycle(PH_MEM_RD, op, 1'b1, "mem_rd");
                do_cycle(PH_MEM_WB, op, rbit(), "mem_wb");
            end
            4'h3: begin
                do_cycle(PH_MEM_ADDR, op, rbit(), "mem_addr");
                for (int i = 0; i < mw; i++) do_cycle(PH_MEM_WR, op, 1'b0, "mem_wr_wait");
                do_cycle(PH_MEM_WR, op, 1'b1, "mem_wr");
            end
            4'h4: do_cycle(PH_BRANCH, op, rbit(), "branch");
            4'h5: do_cycle(PH_JUMP, op, rbit(), "jump");
            default: begin end
        endcase
        if (is_legal(op)) rmodel = rmodel + 1'b1;
    endtask

    // Hold reset across two edges, then release just after an edge: IDLE cycle.
    task automatic do_reset();
        #1;
        rst       = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_outs", 32'(obs), 32'h0);
        chk("rst_ret", 32'(retired), 32'h0);
        rst    = 1'b0;
        rmodel = '0;
        @(negedge clk);
        chk("idle_outs", 32'(obs), 32'h0);
        chk("idle_ret", 32'(retired), 32'h0);
    endtask

    initial begin
        logic [3:0] op;

        do_reset();
        run_instr(4'h0, 0, 0);
        run_instr(4'h1, 0, 0);
        run_instr(4'h2, 0, 3);
        run_instr(4'h7, 0, 0);
        run_instr(4'h4, 0, 0);
        run_instr(4'h3, 2, 1);
        run_instr(4'h5, 1, 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) op = 4'(6 + $urandom_range(0, 8));
            else op = 4'($urandom_range(0, 5));
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        while (rmodel != '1) run_instr(4'h5, 0, 0);
        run_instr(4'h5, 0, 0);
        do_cycle(PH_FETCH, 4'h0, 1'b0, "wrap_fetch");
        chk("wrap_ret_zero", 32'(retired), 32'h0);
        run_instr(4'h0, 0, 0);

        run_instr(4'hF, 0, 0);
        for (int i = 0; i < 20; i++) do_cycle(PH_HALT, 4'($urandom), rbit(), "halt");

        do_reset();
        run_instr(4'h1, 0, 0);
        do_cycle(PH_FETCH, 4'h3, 1'b1, "fetch");
        do_cycle(PH_DECODE, 4'h3, 1'b0, "decode");
        do_cycle(PH_MEM_ADDR, 4'h3, 1'b0, "mem_addr");
        do_cycle(PH_MEM_WR, 4'h3, 1'b0, "mem_wr_wait");
        #2;
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("async_req_drop", 32'(mem_req), 32'h0);
        chk("async_outs", 32'(obs), 32'h0);
        chk("async_ret", 32'(retired), 32'h0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        rmodel = '0;
        @(negedge clk);
        chk("restart_idle", 32'(obs), 32'h0);
        for (int n = 0; n < 30; n++)
            run_instr(4'($urandom_range(0, 5)), $urandom_range(0, 2), $urandom_range(0, 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
